// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, pipeline stall.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish in one CALC cycle using a combinational multiplier.
module muldiv_sequencer #(
   parameter int Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [Width-1:0] rs1_i,
   input  logic [Width-1:0] rs2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [Width-1:0] result_o
);

   localparam int CNT_W = $clog2(Width) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(Width - 1);
   localparam logic [Width-1:0] MIN_NEG = {1'b1, {(Width-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic [Width-1:0]   a_q, b_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*Width-1:0] prod_q;
   logic [Width-1:0]   pending_q, held_q;

   logic               div_zero, div_ovf, special;
   logic [Width-1:0]   special_res;
   logic               a_signed, b_signed, neg_d;
   logic [Width-1:0]   a_mag, b_mag;
   logic [Width:0]     mul_sum, div_shift;
   logic [Width-1:0]   div_diff;
   logic               div_ge;
   logic [2*Width-1:0] step_next;
   logic               calc_last;
   logic [2*Width-1:0] prod_neg;
   logic [Width-1:0]   rem_neg, fix_res;

   // Ops whose result is fixed by the operands alone skip the datapath entirely.
   always_comb begin
      div_zero    = op_i[2] && (rs2_i == '0);
      div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == MIN_NEG) && (rs2_i == '1);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero) begin
         special_res = op_i[1] ? rs1_i : '1;
      end else if (div_ovf) begin
         special_res = op_i[1] ? '0 : rs1_i;
      end
   end

   // The divisor magnitude is needed for REM too, but only the dividend decides its sign.
   always_comb begin
      a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
      b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      a_mag    = (a_signed && a_q[Width-1]) ? -a_q : a_q;
      b_mag    = (b_signed && b_q[Width-1]) ? -b_q : b_q;
      neg_d    = (a_signed && a_q[Width-1]) ^
                 (((op_q == OP_MULH) || (op_q == OP_DIV)) && b_q[Width-1]);
   end

   // prod_q holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*Width-1:Width]} + {1'b0, b_q & {Width{prod_q[0]}}};
      div_shift = prod_q[2*Width-1:Width-1];
      div_ge    = div_shift >= {1'b0, b_q};
      div_diff  = div_shift[Width-1:0] - b_q;
      if (op_q[2]) begin
         step_next = div_ge ? {div_diff, prod_q[Width-2:0], 1'b1}
                            : {div_shift[Width-1:0], prod_q[Width-2:0], 1'b0};
      end else begin
         step_next = {mul_sum, prod_q[Width-1:1]};
      end
`ifdef MULDIV_FAST_MUL_EN
      if (!op_q[2]) begin
         step_next = {{Width{1'b0}}, a_q} * {{Width{1'b0}}, b_q};
      end
      calc_last = !op_q[2] || (cnt_q == LAST_ITER);
`else
      calc_last = (cnt_q == LAST_ITER);
`endif
   end

   always_comb begin
      prod_neg = -prod_q;
      rem_neg  = -prod_q[2*Width-1:Width];
      fix_res  = '0;
      case (op_q)
         OP_MUL:                      fix_res = prod_q[Width-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = neg_q ? prod_neg[2*Width-1:Width] : prod_q[2*Width-1:Width];
         OP_DIV, OP_DIVU:             fix_res = neg_q ? prod_neg[Width-1:0] : prod_q[Width-1:0];
         default:                     fix_res = neg_q ? rem_neg : prod_q[2*Width-1:Width];
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i && !flush_i) state_d = special ? DONE : PREP;
         PREP:    state_d = CALC;
         CALC:    if (calc_last) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // held_q is the architecturally visible result; pending_q only shows through during DONE.
   always_comb begin
      busy_o   = (state_q != IDLE);
      done_o   = (state_q == DONE) && !flush_i;
      stall_o  = !flush_i && (((state_q == IDLE) && start_i) ||
                              (state_q == PREP) || (state_q == CALC) || (state_q == FIX));
      result_o = done_o ? pending_q : held_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         prod_q    <= '0;
         pending_q <= '0;
         held_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && !flush_i) begin
                  op_q <= op_i;
                  a_q  <= rs1_i;
                  b_q  <= rs2_i;
                  if (special) begin
                     pending_q <= special_res;
                  end
               end
            end
            PREP: begin
               a_q    <= a_mag;
               b_q    <= b_mag;
               neg_q  <= neg_d;
               prod_q <= {{Width{1'b0}}, a_mag};
               cnt_q  <= '0;
            end
            CALC: begin
               prod_q <= step_next;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            FIX: begin
               if (!flush_i) begin
                  pending_q <= fix_res;
               end
            end
            DONE: begin
               if (!flush_i) begin
                  held_q <= pending_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
